// File: rtl/muldiv.sv
// muldiv: shared radix-2 multiply/divide engine (MULT/MULTU/DIV/DIVU) with an ABP handshake.
// Revision: 1.0
`default_nettype none

module muldiv #(
  parameter int WIDTH     = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic             sys_clock_i,
  input  logic             sys_reset_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             op_i,
  input  logic             signed_i,
  input  logic             abp_req_i,
  output logic             abp_ack_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              abp_last_q, abp_last_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              op_q, op_d;
  logic              res_neg_q, res_neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic              dz_pend_q, dz_pend_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [W2-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              div_zero_q, div_zero_d;

  logic              a_neg, b_neg;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic              mul_done;
  logic [WIDTH:0]    div_shift;
  logic              div_ge;
  logic [WIDTH-1:0]  rem_next;
  logic [W2-1:0]     prod_fix;
  logic [WIDTH-1:0]  quot_fix, rem_fix;

  assign a_neg = signed_i & a_i[WIDTH-1];
  assign b_neg = signed_i & b_i[WIDTH-1];
  assign a_mag = a_neg ? (WIDTH'(0) - a_i) : a_i;
  assign b_mag = b_neg ? (WIDTH'(0) - b_i) : b_i;

  assign mul_done = EARLY_OUT ? (mplier_q[WIDTH-1:1] == '0) : (cnt_q == LAST_ITER);

  // acc holds {remainder, dividend/quotient}; the dividend shifts out as quotient bits shift in
  assign div_shift = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, mcand_q[WIDTH-1:0]};
  assign rem_next  = div_ge ? (div_shift[WIDTH-1:0] - mcand_q[WIDTH-1:0]) : div_shift[WIDTH-1:0];

  assign prod_fix = res_neg_q ? (W2'(0) - acc_q) : acc_q;
  assign quot_fix = res_neg_q ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign rem_fix  = rem_neg_q ? (WIDTH'(0) - acc_q[W2-1:WIDTH]) : acc_q[W2-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    abp_last_d = abp_last_q;
    ack_d      = ack_q;
    op_d       = op_q;
    res_neg_d  = res_neg_q;
    rem_neg_d  = rem_neg_q;
    dz_pend_d  = dz_pend_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;

    case (state_q)
      IDLE: begin
        if (abp_req_i != abp_last_q) begin
          abp_last_d = abp_req_i;
          op_d       = op_i;
          res_neg_d  = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          rem_neg_d  = signed_i & a_i[WIDTH-1];
          cnt_d      = '0;
          dz_pend_d  = 1'b0;
          state_d    = CALC;
          if (!op_i) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
          end else begin
            acc_d    = {{WIDTH{1'b0}}, a_mag};
            mcand_d  = {{WIDTH{1'b0}}, b_mag};
            // raw dividend kept for the divide-by-zero result
            mplier_d = a_i;
            if (b_i == '0) begin
              dz_pend_d = 1'b1;
              state_d   = FIX;
            end
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (!op_q) begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (mul_done) state_d = FIX;
        end else begin
          acc_d = {rem_next, acc_q[WIDTH-2:0], div_ge};
          if (cnt_q == LAST_ITER) state_d = FIX;
        end
      end
      FIX: begin
        if (!op_q) begin
          hi_d = prod_fix[W2-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (dz_pend_q) begin
          hi_d = mplier_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
        div_zero_d = op_q & dz_pend_q;
        ack_d      = abp_last_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clock_i or posedge sys_reset_i) begin
    if (sys_reset_i) begin
      state_q    <= IDLE;
      abp_last_q <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      op_q       <= 1'b0;
      res_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      dz_pend_q  <= 1'b0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      abp_last_q <= abp_last_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      op_q       <= op_d;
      res_neg_q  <= res_neg_d;
      rem_neg_q  <= rem_neg_d;
      dz_pend_q  <= dz_pend_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign abp_ack_o  = ack_q;
  assign busy_o     = busy_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign div_zero_o = div_zero_q;

endmodule

`default_nettype wire

// File: doc/muldiv.md
# muldiv

Parametrised, shared-datapath integer multiply/divide unit for the M1 CPU execute stage, serving MULT/MULTU/DIV/DIVU. One radix-2 shift/add-subtract engine handles both operations, with operand width set by `WIDTH`. Adds early-out for short multipliers, divide-by-zero detection, MIPS-correct signed remainder and a busy indication. Talks to the pipeline over an Alternating Bit Protocol (ABP) request/acknowledge pair.

## Interface
- `WIDTH`, 32: operand width; even, ≥4.
- `EARLY_OUT`, 1: 1 enables multiply early termination; 0 gives fixed latency.

- `sys_clock_i`  in  1  system clock; all state changes on the rising edge.
- `sys_reset_i`  in  1  asynchronous, active-high reset.
- `a_i`  in  WIDTH  multiplicand / dividend.
- `b_i`  in  WIDTH  multiplier / divisor.
- `op_i`  in  1  0 = multiply, 1 = divide.
- `signed_i`  in  1  1 = two's-complement operands.
- `abp_req_i`  in  1  ABP request; a toggle starts an operation.
- `abp_ack_o`  out  1  ABP acknowledge; set equal to the request level on completion.
- `busy_o`  out  1  high whenever state ≠ IDLE.
- `hi_o`  out  WIDTH  product high half / remainder.
- `lo_o`  out  WIDTH  product low half / quotient.
- `div_zero_o`  out  1  last completed operation was a divide by zero.

## Operation
- States: IDLE, CALC, FIX.
- IDLE: when `abp_req_i != abp_last`, accept the request on that edge:
  - store `abp_last`, `op_i` and `signed_i`;
  - store magnitudes of `a_i` and `b_i`; a value is negated only when `signed_i` is set and its MSB is 1;
  - store the result sign, `signed_i & (a[MSB]^b[MSB])`;
  - store the remainder sign, `signed_i & a[MSB]`.
- After accept, go to CALC. Exception: a divide with `b_i == 0` goes straight to FIX.
- `a_i`, `b_i`, `op_i` and `signed_i` are sampled only on the accept edge.
- CALC, multiply: 2·WIDTH accumulator. Per cycle, add the shifted |a| if the multiplier LSB is 1, then shift.
  - EARLY_OUT=1: leave CALC once the remaining multiplier bits are all zero. Iterations = max(1, bitlen(|b|)).
  - EARLY_OUT=0: WIDTH iterations.
- CALC, divide: restoring division, always WIDTH iterations. Per cycle, trial-subtract the shifted divisor; if non-negative, keep the difference and set the quotient bit.
- FIX, one cycle:
  - multiply: `{hi_o, lo_o}` = accumulator, negated if the result sign is set;
  - divide: `lo_o` = quotient, negated if the result sign is set; `hi_o` = remainder, negated if the remainder sign is set (remainder follows dividend, quotient truncates toward zero);
  - divide by zero: `lo_o` = all ones, `hi_o` = `a_i` as sampled at accept, `div_zero_o` = 1;
  - all other operations: `div_zero_o` = 0;
  - `abp_ack_o` ← `abp_last`; go to IDLE.
- Signed overflow, most-negative / −1: `lo_o` = most-negative (wrap), `hi_o` = 0, no flag.
- Arithmetic is modulo 2^WIDTH per output half; no saturation.
- Outputs hold their values until the next FIX. CALC never writes `hi_o` or `lo_o`.
- A request toggle during CALC/FIX is a protocol violation. It is not lost: the request is accepted from IDLE on the edge after FIX, because req ≠ `abp_last`.

## Timing
- Accept edge E0; CALC occupies edges E1..Ek; FIX is edge Ek+1.
  - Results and `abp_ack_o` are valid after edge Ek+1.
  - Divide: k = WIDTH.
  - Divide by zero: k = 0.
  - Multiply: k as defined in Operation.
- `busy_o` rises after E0 and falls after Ek+1.
- Back-to-back: the next request can be accepted on edge Ek+2.
- Reset, asynchronous at any point including mid-CALC, immediately gives:
  - state IDLE;
  - `abp_ack_o`, `abp_last`, `busy_o`, `div_zero_o` = 0;
  - `hi_o`, `lo_o` = 0.
- The requester must also return `abp_req_i` to 0 during reset; otherwise a spurious request is accepted on the first edge after release.

## Test plan
- WIDTH=32, EARLY_OUT=1, unsigned 17×3 -> `lo_o`=51, `hi_o`=0; ack toggles on the 3rd edge after accept (k=2); `busy_o` high for exactly 3 cycles.
- Signed −7×3 -> `hi_o`=0xFFFFFFFF, `lo_o`=0xFFFFFFEB. Unsigned 0xFFFFFFFF×0xFFFFFFFF -> `hi_o`=0xFFFFFFFE, `lo_o`=0x00000001, ack on the 33rd edge.
- Signed −17/5 -> q=0xFFFFFFFD, r=0xFFFFFFFE. Signed 17/−5 -> q=0xFFFFFFFD, r=2. Unsigned 17/5 -> q=3, r=2. Each acks on the 33rd edge.
- Divide by zero, 100/0 -> `lo_o`=0xFFFFFFFF, `hi_o`=100, `div_zero_o`=1, ack on the 1st edge. A following 20/4 -> q=5, r=0, `div_zero_o`=0. Signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0.
- Reset asserted asynchronously at cycle 10 of a divide -> all outputs 0 without a clock edge. After release with req=0, a fresh request completes correctly.
- WIDTH=8, EARLY_OUT=0, unsigned 255×255 -> `hi_o`=0xFE, `lo_o`=0x01; ack on the 9th edge. Also 3×2 acks on the 9th edge (fixed latency).
